// File: rtl/agen_pipe_pkg.sv
// Shared types and helpers for the pipelined address generation unit.
package agen_pipe_pkg;

    // Default configuration widths for bus-level wrappers that use the structs below.
    localparam int unsigned AGEN_AWID = 52;
    localparam int unsigned AGEN_TAGW = 5;
    localparam int unsigned AGEN_SCW  = 2;

    typedef enum logic [1:0] {
        AM_DISP    = 2'b00,
        AM_INDEX   = 2'b01,
        AM_POSTINC = 2'b10,
        AM_PREDEC  = 2'b11
    } agen_mode_e;

    typedef struct packed {
        agen_mode_e            mode;
        logic [1:0]            size;
        logic [AGEN_SCW-1:0]   scale;
        logic [AGEN_AWID-1:0]  src1;
        logic [AGEN_AWID-1:0]  src2;
        logic [AGEN_AWID-1:0]  src3;
        logic [AGEN_AWID-1:0]  lim;
        logic [AGEN_TAGW-1:0]  tag;
    } agen_req_t;

    typedef struct packed {
        logic [AGEN_AWID-1:0]  ma;
        logic [AGEN_AWID-1:0]  wb;
        logic                  wb_en;
        logic                  misalign;
        logic                  limit;
        logic [AGEN_TAGW-1:0]  tag;
    } agen_rsp_t;

    // Access size in bytes from its log2 encoding (1, 2, 4, 8).
    function automatic logic [3:0] agen_size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/agen_ea_calc.sv
// Combinational effective-address and base-writeback calculation for one AGEN channel.
module agen_ea_calc
    import agen_pipe_pkg::*;
#(
    parameter int unsigned AWID = 52,
    parameter int unsigned SCW  = 2
) (
    input  logic [1:0]      mode_i,
    input  logic [1:0]      size_i,
    input  logic [SCW-1:0]  scale_i,
    input  logic [AWID-1:0] src1_i,
    input  logic [AWID-1:0] src2_i,
    input  logic [AWID-1:0] src3_i,
    output logic [AWID-1:0] ma_o,
    output logic [AWID-1:0] wb_o,
    output logic            wb_en_o
);

    logic [AWID-1:0] w_sz;

    // Mode decode; all arithmetic wraps modulo 2^AWID. wb is zero for non-modify modes.
    always_comb begin
        w_sz    = AWID'(agen_size_bytes(size_i));
        ma_o    = '0;
        wb_o    = '0;
        wb_en_o = mode_i[1];
        unique case (agen_mode_e'(mode_i))
            AM_DISP:    ma_o = src1_i + src2_i;
            AM_INDEX:   ma_o = src2_i + (src3_i << scale_i);
            AM_POSTINC: begin
                ma_o = src1_i;
                wb_o = src1_i + w_sz;
            end
            AM_PREDEC:  begin
                ma_o = src1_i - w_sz;
                wb_o = src1_i - w_sz;
            end
            default:    ;
        endcase
    end

endmodule

// File: rtl/agen_pipe.sv
// Two-stage pipelined address generation unit with valid/ready handshake and flush.
module agen_pipe
    import agen_pipe_pkg::*;
#(
    parameter int unsigned AWID      = 52,
    parameter int unsigned TAGW      = 5,
    parameter int unsigned SCW       = 2,
    parameter bit          ALIGN_CHK = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      mode_i,
    input  logic [1:0]      size_i,
    input  logic [SCW-1:0]  scale_i,
    input  logic [AWID-1:0] src1_i,
    input  logic [AWID-1:0] src2_i,
    input  logic [AWID-1:0] src3_i,
    input  logic [AWID-1:0] lim_i,
    input  logic [TAGW-1:0] tag_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [AWID-1:0] ma_o,
    output logic [AWID-1:0] wb_o,
    output logic            wb_en_o,
    output logic            misalign_o,
    output logic            limit_o,
    output logic [TAGW-1:0] tag_o,
    output logic            idle_o
);

    localparam int unsigned EW = AWID + 1;

    // S1 state
    logic            r_s1_valid;
    logic [AWID-1:0] r_s1_ma;
    logic [AWID-1:0] r_s1_wb;
    logic            r_s1_wb_en;
    logic [1:0]      r_s1_size;
    logic [AWID-1:0] r_s1_lim;
    logic [TAGW-1:0] r_s1_tag;

    // S2 state (drives the outputs directly)
    logic            r_s2_valid;
    logic [AWID-1:0] r_s2_ma;
    logic [AWID-1:0] r_s2_wb;
    logic            r_s2_wb_en;
    logic            r_s2_misalign;
    logic            r_s2_limit;
    logic [TAGW-1:0] r_s2_tag;

    logic            w_s1_ready;
    logic            w_s2_ready;
    logic            w_in_fire;
    logic            w_s1_adv;
    logic [AWID-1:0] w_ea_ma;
    logic [AWID-1:0] w_ea_wb;
    logic            w_ea_wb_en;
    logic [AWID-1:0] w_s2_sz;
    logic [EW-1:0]   w_s2_end;
    logic            w_s2_misalign;
    logic            w_s2_limit;

    assign w_s2_ready = !r_s2_valid | out_ready_i;
    assign w_s1_ready = !r_s1_valid | w_s2_ready;
    assign in_ready_o = w_s1_ready;

    // Flush suppresses every data movement on its edge.
    assign w_in_fire = in_valid_i & w_s1_ready & !flush_i;
    assign w_s1_adv  = r_s1_valid & w_s2_ready & !flush_i;

    agen_ea_calc #(
        .AWID (AWID),
        .SCW  (SCW)
    ) u_ea_calc (
        .mode_i  (mode_i),
        .size_i  (size_i),
        .scale_i (scale_i),
        .src1_i  (src1_i),
        .src2_i  (src2_i),
        .src3_i  (src3_i),
        .ma_o    (w_ea_ma),
        .wb_o    (w_ea_wb),
        .wb_en_o (w_ea_wb_en)
    );

    // S2 checks: one extra bit on the end address so a carry out reads as over the limit.
    assign w_s2_sz       = AWID'(agen_size_bytes(r_s1_size));
    assign w_s2_misalign = ALIGN_CHK && ((r_s1_ma & (w_s2_sz - AWID'(1))) != '0);
    assign w_s2_end      = {1'b0, r_s1_ma} + {1'b0, w_s2_sz} - EW'(1);
    assign w_s2_limit    = w_s2_end > {1'b0, r_s1_lim};

    // S1 register: capture a new op when the stage can accept it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_ma    <= '0;
            r_s1_wb    <= '0;
            r_s1_wb_en <= 1'b0;
            r_s1_size  <= '0;
            r_s1_lim   <= '0;
            r_s1_tag   <= '0;
        end else begin
            if (flush_i) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_ready) begin
                r_s1_valid <= in_valid_i;
            end
            if (w_in_fire) begin
                r_s1_ma    <= w_ea_ma;
                r_s1_wb    <= w_ea_wb;
                r_s1_wb_en <= w_ea_wb_en;
                r_s1_size  <= size_i;
                r_s1_lim   <= lim_i;
                r_s1_tag   <= tag_i;
            end
        end
    end

    // S2 register: take S1's op with its fault flags; hold everything while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid    <= 1'b0;
            r_s2_ma       <= '0;
            r_s2_wb       <= '0;
            r_s2_wb_en    <= 1'b0;
            r_s2_misalign <= 1'b0;
            r_s2_limit    <= 1'b0;
            r_s2_tag      <= '0;
        end else begin
            if (flush_i) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_adv) begin
                r_s2_ma       <= r_s1_ma;
                r_s2_wb       <= r_s1_wb;
                r_s2_wb_en    <= r_s1_wb_en;
                r_s2_misalign <= w_s2_misalign;
                r_s2_limit    <= w_s2_limit;
                r_s2_tag      <= r_s1_tag;
            end
        end
    end

    assign out_valid_o = r_s2_valid;
    assign ma_o        = r_s2_ma;
    assign wb_o        = r_s2_wb;
    assign wb_en_o     = r_s2_wb_en;
    assign misalign_o  = r_s2_misalign;
    assign limit_o     = r_s2_limit;
    assign tag_o       = r_s2_tag;
    assign idle_o      = !r_s1_valid & !r_s2_valid;

endmodule

// File: tb/tb_agen_pipe.sv
// Self-checking bench for agen_pipe: queue-based reference model plus directed literal cases.
module tb_agen_pipe;

    localparam int unsigned AWID = 52;
    localparam int unsigned TAGW = 5;
    localparam int unsigned SCW  = 2;
    localparam logic [AWID-1:0] ONES = '1;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [1:0]      mode_i;
    logic [1:0]      size_i;
    logic [SCW-1:0]  scale_i;
    logic [AWID-1:0] src1_i;
    logic [AWID-1:0] src2_i;
    logic [AWID-1:0] src3_i;
    logic [AWID-1:0] lim_i;
    logic [TAGW-1:0] tag_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [AWID-1:0] ma_o;
    logic [AWID-1:0] wb_o;
    logic            wb_en_o;
    logic            misalign_o;
    logic            limit_o;
    logic [TAGW-1:0] tag_o;
    logic            idle_o;

    agen_pipe #(
        .AWID      (AWID),
        .TAGW      (TAGW),
        .SCW       (SCW),
        .ALIGN_CHK (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mode_i      (mode_i),
        .size_i      (size_i),
        .scale_i     (scale_i),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .src3_i      (src3_i),
        .lim_i       (lim_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .ma_o        (ma_o),
        .wb_o        (wb_o),
        .wb_en_o     (wb_en_o),
        .misalign_o  (misalign_o),
        .limit_o     (limit_o),
        .tag_o       (tag_o),
        .idle_o      (idle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AWID-1:0] ma;
        logic [AWID-1:0] wb;
        bit              wb_en;
        bit              mis;
        bit              lim;
        logic [TAGW-1:0] tag;
        int              acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pop = 0;
    int   cyc   = 0;

    bit              held = 1'b0;
    logic [AWID-1:0] h_ma;
    logic [AWID-1:0] h_wb;
    logic            h_en;
    logic            h_mis;
    logic            h_lim;
    logic [TAGW-1:0] h_tag;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference result from the op's plain arithmetic meaning.
    function automatic exp_t model(input logic [1:0] mode, input logic [1:0] size,
                                   input logic [SCW-1:0] scale, input logic [AWID-1:0] s1,
                                   input logic [AWID-1:0] s2, input logic [AWID-1:0] s3,
                                   input logic [AWID-1:0] lim, input logic [TAGW-1:0] tag);
        exp_t e;
        longint unsigned mask, sz, a1, a2, a3, ma, wb;
        mask = (64'd1 << AWID) - 64'd1;
        sz   = 64'd1 << size;
        a1   = 64'(s1);
        a2   = 64'(s2);
        a3   = 64'(s3);
        wb   = 0;
        case (mode)
            2'd0:    ma = (a1 + a2) & mask;
            2'd1:    ma = (a2 + a3 * (64'd1 << scale)) & mask;
            2'd2:    begin ma = a1; wb = (a1 + sz) & mask; end
            default: begin ma = (a1 - sz) & mask; wb = ma; end
        endcase
        e.ma    = AWID'(ma);
        e.wb    = AWID'(wb);
        e.wb_en = mode[1];
        e.mis   = (ma % sz) != 0;
        e.lim   = (ma + sz - 64'd1) > 64'(lim);
        e.tag   = tag;
        e.acc   = cyc;
        return e;
    endfunction

    always @(posedge clk_i) cyc++;

    // Compare process: every cycle, check DUT against the model queue, then advance the model.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            q.delete();
            held = 1'b0;
        end else begin
            check("in_ready", in_ready_o, (q.size() < 2) || out_ready_i);
            check("out_valid", out_valid_o, (q.size() > 0) && (cyc - q[0].acc >= 2));
            check("idle", idle_o, q.size() == 0);
            if (out_valid_o && q.size() > 0) begin
                check("sb_ma", ma_o, q[0].ma);
                if (q[0].wb_en) check("sb_wb", wb_o, q[0].wb);
                check("sb_wb_en", wb_en_o, q[0].wb_en);
                check("sb_misalign", misalign_o, q[0].mis);
                check("sb_limit", limit_o, q[0].lim);
                check("sb_tag", tag_o, q[0].tag);
            end
            if (held) begin
                check("hold_ma", ma_o, h_ma);
                check("hold_wb", wb_o, h_wb);
                check("hold_flags", {wb_en_o, misalign_o, limit_o}, {h_en, h_mis, h_lim});
                check("hold_tag", tag_o, h_tag);
            end
            held  = out_valid_o && !out_ready_i && !flush_i;
            h_ma  = ma_o;
            h_wb  = wb_o;
            h_en  = wb_en_o;
            h_mis = misalign_o;
            h_lim = limit_o;
            h_tag = tag_o;
            if (flush_i) begin
                q.delete();
            end else begin
                if (out_valid_o && out_ready_i && q.size() > 0) begin
                    void'(q.pop_front());
                    n_pop++;
                end
                if (in_valid_i && in_ready_o)
                    q.push_back(model(mode_i, size_i, scale_i, src1_i, src2_i, src3_i,
                                      lim_i, tag_i));
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [AWID-1:0] rnd52();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[AWID-1:0];
    endfunction

    task automatic set_rand_op();
        mode_i  = 2'($urandom_range(0, 3));
        size_i  = 2'($urandom_range(0, 3));
        scale_i = SCW'($urandom_range(0, 3));
        tag_i   = TAGW'($urandom());
        case ($urandom_range(0, 2))
            0: begin
                src1_i = AWID'($urandom_range(0, 16'hFFFF));
                src2_i = AWID'($urandom_range(0, 16'hFFFF));
                src3_i = AWID'($urandom_range(0, 16'hFF));
            end
            1: begin
                src1_i = ONES - AWID'($urandom_range(0, 15));
                src2_i = AWID'($urandom_range(0, 15));
                src3_i = AWID'($urandom_range(0, 3));
            end
            default: begin
                src1_i = rnd52();
                src2_i = rnd52();
                src3_i = rnd52();
            end
        endcase
        case ($urandom_range(0, 2))
            0:       lim_i = ONES;
            1:       lim_i = AWID'($urandom_range(0, 17'h1FFFF));
            default: lim_i = rnd52();
        endcase
    endtask

    // Single op through an empty pipe, checked against hand-computed literals.
    task automatic run_one(input string nm, input logic [1:0] mode, input logic [1:0] size,
                           input logic [SCW-1:0] scale, input logic [AWID-1:0] s1,
                           input logic [AWID-1:0] s2, input logic [AWID-1:0] s3,
                           input logic [AWID-1:0] lim, input logic [TAGW-1:0] tag,
                           input logic [AWID-1:0] e_ma, input logic [AWID-1:0] e_wb,
                           input logic e_en, input logic e_mis, input logic e_lim);
        int k;
        mode_i = mode; size_i = size; scale_i = scale;
        src1_i = s1; src2_i = s2; src3_i = s3; lim_i = lim; tag_i = tag;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        step();
        in_valid_i = 1'b0;
        k = 0;
        while (k < 8) begin
            @(negedge clk_i);
            if (out_valid_o) break;
            k++;
        end
        check({nm, "_latency"}, 64'(k), 64'd1);
        check({nm, "_ma"}, ma_o, e_ma);
        if (e_en) check({nm, "_wb"}, wb_o, e_wb);
        check({nm, "_wb_en"}, wb_en_o, e_en);
        check({nm, "_misalign"}, misalign_o, e_mis);
        check({nm, "_limit"}, limit_o, e_lim);
        check({nm, "_tag"}, tag_o, tag);
        step();
    endtask

    int stall;
    int n0;

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        mode_i = '0; size_i = '0; scale_i = '0; tag_i = '0;
        src1_i = '0; src2_i = '0; src3_i = '0; lim_i = '0;
        repeat (3) step();
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_idle", idle_o, 1'b1);
        check("rst_in_ready", in_ready_o, 1'b1);
        check("rst_data", {ma_o, wb_o, tag_o}, '0);
        check("rst_flags", {wb_en_o, misalign_o, limit_o}, 3'b000);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        step();

        // Directed literal cases
        run_one("disp", 2'd0, 2'd2, 2'd0, 52'h1000, 52'h24, 52'h0, ONES, 5'd5,
                52'h1024, 52'h0, 1'b0, 1'b0, 1'b0);
        run_one("idx_s3", 2'd1, 2'd3, 2'd3, 52'h0, 52'h2000, 52'h3, ONES, 5'd6,
                52'h2018, 52'h0, 1'b0, 1'b0, 1'b0);
        run_one("idx_s2", 2'd1, 2'd2, 2'd3, 52'h0, 52'h2000, 52'h1, ONES, 5'd7,
                52'h2008, 52'h0, 1'b0, 1'b0, 1'b0);
        run_one("idx_mis", 2'd1, 2'd3, 2'd0, 52'h0, 52'h2000, 52'h4, ONES, 5'd8,
                52'h2004, 52'h0, 1'b0, 1'b1, 1'b0);
        run_one("postinc", 2'd2, 2'd3, 2'd0, 52'h100, 52'h0, 52'h0, ONES, 5'd9,
                52'h100, 52'h108, 1'b1, 1'b0, 1'b0);
        run_one("predec", 2'd3, 2'd3, 2'd0, 52'h100, 52'h0, 52'h0, ONES, 5'd10,
                52'hF8, 52'hF8, 1'b1, 1'b0, 1'b0);
        run_one("lim_ok", 2'd0, 2'd2, 2'd0, 52'h1FFC, 52'h0, 52'h0, 52'h1FFF, 5'd11,
                52'h1FFC, 52'h0, 1'b0, 1'b0, 1'b0);
        run_one("lim_over", 2'd0, 2'd2, 2'd0, 52'h1FFE, 52'h0, 52'h0, 52'h1FFF, 5'd12,
                52'h1FFE, 52'h0, 1'b0, 1'b1, 1'b1);
        run_one("wrap", 2'd0, 2'd2, 2'd0, ONES - 52'd3, 52'h8, 52'h0, ONES, 5'd13,
                52'h4, 52'h0, 1'b0, 1'b0, 1'b0);
        run_one("carry", 2'd2, 2'd3, 2'd0, ONES - 52'd3, 52'h0, 52'h0, ONES, 5'd14,
                ONES - 52'd3, 52'h4, 1'b1, 1'b1, 1'b1);

        // Backpressure: 4 ops, consumer stalls from the third op on
        out_ready_i = 1'b1;
        n0 = n_pop;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) out_ready_i = 1'b0;
            set_rand_op();
            in_valid_i = 1'b1;
            #1;
            if (i == 2) check("bp_in_ready_drop", in_ready_o, 1'b0);
            stall = 0;
            while (!in_ready_o && stall < 20) begin
                step();
                stall++;
                if (stall == 3) out_ready_i = 1'b1;
                #1;
            end
            if (!in_ready_o) check("bp_accept_timeout", 64'd0, 64'd1);
            step();
        end
        in_valid_i = 1'b0;
        repeat (4) step();
        check("bp_delivered", 64'(n_pop - n0), 64'd4);

        // Flush with two ops in flight and a new op offered on the flush edge
        out_ready_i = 1'b1;
        set_rand_op(); in_valid_i = 1'b1;
        step();
        set_rand_op();
        step();
        out_ready_i = 1'b0;
        flush_i = 1'b1;
        set_rand_op();
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        #1;
        check("flush_out_valid", out_valid_o, 1'b0);
        check("flush_idle", idle_o, 1'b1);
        out_ready_i = 1'b1;
        step();

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 1500; i++) begin
            set_rand_op();
            in_valid_i  = ($urandom_range(0, 9) < 7);
            out_ready_i = ($urandom_range(0, 9) < 7);
            flush_i     = ($urandom_range(0, 49) == 0);
            step();
        end
        in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        repeat (4) step();
        check("drain_idle", idle_o, 1'b1);

        // Asynchronous reset mid-stream
        out_ready_i = 1'b0;
        set_rand_op(); in_valid_i = 1'b1;
        step();
        set_rand_op();
        step();
        in_valid_i = 1'b0;
        check("arst_pre_valid", out_valid_o, 1'b1);
        #1 rst_ni = 1'b0;
        #1;
        check("arst_out_valid", out_valid_o, 1'b0);
        check("arst_idle", idle_o, 1'b1);
        check("arst_ma", ma_o, 52'h0);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        out_ready_i = 1'b1;
        step();
        run_one("post_rst", 2'd0, 2'd0, 2'd0, 52'h40, 52'h3, 52'h0, 52'h42, 5'd31,
                52'h43, 52'h0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
